jpeg_rle_encoder: RTL
=====================

# jpeg_rle_encoder

Run-length and amplitude encoder that consumes one zigzag-ordered 8x8 coefficient block, for a single channel (y, cb or cr), from `jpeg_compression_pipeline`. It emits one JPEG symbol per handshake: a DC differential, AC (run, size, amplitude) symbols, ZRL and EOB. Its output is the symbol stream for the downstream Huffman coder. One instance is used per channel.

## Interface
- `DATA_WIDTH`, 32: width of each input coefficient (signed two's complement integer).
- `DATA_DEPTH`, 8: block edge. The block holds `DATA_DEPTH*DATA_DEPTH` = 64 coefficients; only 8 is supported.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `coef_all` input DATA_WIDTH*64: zigzag block. Index i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`; index 0 is DC.
- `in_valid` input 1: `coef_all` holds a block.
- `in_ready` output 1: the encoder can accept a block.
- `dc_clear` input 1: clears the DC predictor to 0. Sampled only while `in_ready`=1.
- `out_valid` output 1: a symbol is presented.
- `out_ready` input 1: downstream accepts the symbol.
- `out_run` output 4: zero run before the coefficient.
- `out_size` output 4: magnitude category, 0..11.
- `out_amp` output 11: JPEG amplitude bits, LSB-aligned, upper bits 0.
- `out_is_dc` output 1: the symbol is the DC differential.
- `out_last` output 1: final symbol of the block.

## Operation
- States: IDLE, DC, SCAN, EOB.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: register all 64 coefficients, clipping each to ±2047.
  - In the same cycle, compute `last_nz` = highest index 1..63 with a nonzero clipped coefficient, or 0 if there is none.
  - Go to DC.
- DC:
  - Emit diff = clip(coef[0] − prev_dc, ±2047) with run 0 and `out_is_dc`=1.
  - On acceptance: `prev_dc` ← coef[0], idx ← 1, run ← 0.
  - Next state is EOB if `last_nz`=0, else SCAN.
- SCAN: examine coef[idx] once per step.
  - Zero coefficient: run ← run+1 with no emission, taking one cycle. If run reaches 16, emit ZRL (run 15, size 0, amp 0) and set run ← 0 on acceptance.
  - Nonzero coefficient: clip to ±1023, emit (run, size, amp), then run ← 0 on acceptance.
  - After an emitted symbol is accepted, or after a non-emitting step:
    - If idx = `last_nz` and `last_nz` = 63: return to IDLE; that symbol carries `out_last`=1.
    - Else if idx = `last_nz`: go to EOB.
    - Otherwise idx ← idx+1.
- EOB: emit (run 0, size 0, amp 0) with `out_last`=1. Return to IDLE on acceptance.
- Size and amplitude rules:
  - size = bit length of |v|; size = 0 when v = 0.
  - amp = v when v > 0; amp = (v − 1) masked to size bits when v < 0.
- DC predictor:
  - `prev_dc` resets to 0.
  - `dc_clear` is honoured in IDLE. If it coincides with a block capture, the cleared predictor is used for that block.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, all symbol fields 0, `prev_dc`=0, state IDLE.
- Reset asserted mid-block discards the block and the pending symbol. `in_ready`=1 on the following cycle.
- Latency: a handshake in cycle 0 gives the DC symbol with `out_valid`=1 in cycle 1.
- AC symbols appear with a gap of one cycle per non-emitting zero step.
- `in_ready` is high in the cycle after the `out_last` handshake.
- Output hold rule: while `out_valid && !out_ready`, all `out_*` fields hold stable and idx and run do not advance.
- `out_valid` never drops without a handshake, except on reset.
- Back-to-back symbols: a symbol accepted in cycle t allows the next symbol in cycle t+1 at full rate (no bubble).
- Throughput bound per block: 1 capture cycle + (at most 64 steps + stalls).

## Test plan
- All-zero block after reset -> DC (size 0, amp 0, `out_is_dc`) then EOB with `out_last`; no AC symbols; `in_ready` high in the following cycle.
- DC sequence 100, 90, 90 across three blocks with all AC zero -> diffs +100 (size 7, amp 0x64), −10 (size 4, amp 0x5), 0 (size 0).
- Single AC −3 at index 63, rest zero -> DC, three ZRLs (15/0), then run 14, size 2, amp 0b00, `out_last`=1; no EOB.
- AC +5 at index 2 and −1024 at index 3 -> (run 1, size 3, amp 0x5), (run 0, size 10, amp 0x000 from the −1023 clip), EOB.
- `out_ready` toggled pseudo-randomly -> symbol fields stable during every stall; same symbol sequence as with `out_ready`=1.
- Reset asserted during SCAN -> `out_valid`=0 next cycle; the next block's DC uses `prev_dc`=0.

Source files
------------

// File: rtl/jpeg_rle_encoder_if.sv
// Handshake bundle between the coefficient producer and jpeg_rle_encoder:
// one zigzag block in, one JPEG symbol out per accepted transfer.
interface jpeg_rle_encoder_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH*64-1:0] coef_all;
    logic                     in_valid;
    logic                     in_ready;
    logic                     dc_clear;
    logic                     out_valid;
    logic                     out_ready;
    logic [3:0]               out_run;
    logic [3:0]               out_size;
    logic [10:0]              out_amp;
    logic                     out_is_dc;
    logic                     out_last;

    modport master (
        output coef_all, in_valid, dc_clear, out_ready,
        input  in_ready, out_valid, out_run, out_size, out_amp, out_is_dc, out_last
    );

    modport slave (
        input  coef_all, in_valid, dc_clear, out_ready,
        output in_ready, out_valid, out_run, out_size, out_amp, out_is_dc, out_last
    );
endinterface

// File: rtl/jpeg_rle_encoder.sv
// Run-length / amplitude encoder for one zigzag 8x8 block: emits the DC
// differential, AC (run, size, amp) symbols, ZRL and EOB, one per handshake.
module jpeg_rle_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8
) (
    input logic               clk,
    input logic               reset,
    jpeg_rle_encoder_if.slave bus
);
    localparam int N = DATA_DEPTH * DATA_DEPTH;
    localparam logic signed [DATA_WIDTH-1:0] IN_MAX = DATA_WIDTH'(2047);
    localparam logic signed [DATA_WIDTH-1:0] IN_MIN = -IN_MAX;

    typedef enum logic [1:0] {IDLE, DC, SCAN, EOB} state_t;
    typedef struct packed {
        logic [3:0]  size;
        logic [10:0] amp;
    } sym_t;

    state_t             state_q, state_d;
    logic signed [11:0] coef_q [N];
    logic signed [11:0] coef_d [N];
    logic signed [11:0] clipped [N];
    logic [5:0]         last_nz_q, last_nz_d, last_nz_cap;
    logic [5:0]         idx_q, idx_d;
    logic [3:0]         run_q, run_d;
    logic signed [11:0] prev_dc_q, prev_dc_d;

    logic        in_ready, out_valid, out_is_dc, out_last;
    logic [3:0]  out_run;
    sym_t        out_sym;

    function automatic logic signed [11:0] clip_in(input logic signed [DATA_WIDTH-1:0] v);
        if (v > IN_MAX)      return 12'sd2047;
        else if (v < IN_MIN) return -12'sd2047;
        else                 return 12'(v);
    endfunction

    function automatic logic signed [12:0] clip_ac(input logic signed [11:0] c);
        if (c > 12'sd1023)       return 13'sd1023;
        else if (c < -12'sd1023) return -13'sd1023;
        else                     return $signed({c[11], c});
    endfunction

    // v is already limited to +-2047, so the magnitude fits in 11 bits.
    function automatic sym_t encode(input logic signed [12:0] v);
        sym_t        s;
        logic [10:0] mag;
        logic [10:0] mask;
        mag    = 11'(v[12] ? -v : v);
        s.size = '0;
        for (int b = 0; b < 11; b++) begin
            if (mag[b]) s.size = 4'(b + 1);
        end
        mask  = 11'((12'h1 << s.size) - 12'h1);
        s.amp = v[12] ? (11'(v - 13'sd1) & mask) : v[10:0];
        return s;
    endfunction

    always_comb begin
        last_nz_cap = '0;
        for (int i = 0; i < N; i++) begin
            clipped[i] = clip_in(bus.coef_all[i*DATA_WIDTH +: DATA_WIDTH]);
        end
        for (int i = 1; i < N; i++) begin
            if (clipped[i] != 12'sd0) last_nz_cap = 6'(i);
        end
    end

    logic signed [12:0] dc_raw, dc_diff;
    logic signed [11:0] cur;
    logic               at_last, step_emit;

    always_comb begin
        dc_raw = $signed({coef_q[0][11], coef_q[0]}) - $signed({prev_dc_q[11], prev_dc_q});
        if (dc_raw > 13'sd2047)       dc_diff = 13'sd2047;
        else if (dc_raw < -13'sd2047) dc_diff = -13'sd2047;
        else                          dc_diff = dc_raw;
    end

    assign cur       = coef_q[idx_q];
    assign at_last   = (idx_q == last_nz_q);
    assign step_emit = (cur != 12'sd0) || (run_q == 4'd15);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves a latch.
        state_d   = state_q;
        coef_d    = coef_q;
        last_nz_d = last_nz_q;
        idx_d     = idx_q;
        run_d     = run_q;
        prev_dc_d = prev_dc_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_run   = '0;
        out_sym   = '0;
        out_is_dc = 1'b0;
        out_last  = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.dc_clear) prev_dc_d = '0;
                if (bus.in_valid) begin
                    coef_d    = clipped;
                    last_nz_d = last_nz_cap;
                    state_d   = DC;
                end
            end
            DC: begin
                out_valid = 1'b1;
                out_is_dc = 1'b1;
                out_sym   = encode(dc_diff);
                if (bus.out_ready) begin
                    prev_dc_d = coef_q[0];
                    idx_d     = 6'd1;
                    run_d     = '0;
                    state_d   = (last_nz_q == 6'd0) ? EOB : SCAN;
                end
            end
            SCAN: begin
                out_valid = step_emit;
                out_last  = at_last && (last_nz_q == 6'd63);
                if (cur != 12'sd0) begin
                    out_run = run_q;
                    out_sym = encode(clip_ac(cur));
                end else if (run_q == 4'd15) begin
                    out_run = 4'd15;  // ZRL: sixteenth zero in a row
                end
                if (!step_emit || bus.out_ready) begin
                    run_d = step_emit ? 4'd0 : run_q + 4'd1;
                    if (at_last) state_d = (last_nz_q == 6'd63) ? IDLE : EOB;
                    else         idx_d   = idx_q + 6'd1;
                end
            end
            EOB: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_nz_q <= '0;
            idx_q     <= '0;
            run_q     <= '0;
            prev_dc_q <= '0;
        end else begin
            state_q   <= state_d;
            last_nz_q <= last_nz_d;
            idx_q     <= idx_d;
            run_q     <= run_d;
            prev_dc_q <= prev_dc_d;
        end
    end

    // NOTE: coefficient storage is always written by a capture before it is read, so it has no reset.
    always_ff @(posedge clk) begin
        coef_q <= coef_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_run   = out_run;
    assign bus.out_size  = out_sym.size;
    assign bus.out_amp   = out_sym.amp;
    assign bus.out_is_dc = out_is_dc;
    assign bus.out_last  = out_last;
endmodule
